// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-supply front end. Owns the fetch PC, issues word fetches to
// instruction memory (req/gnt, fixed one-cycle read latency) and hands
// {instr, pc} to decode through a FIFO_DEPTH-entry prefetch buffer using a
// valid/ready handshake. A PC-select redirect (pc_src_i + pc_target_i) flushes
// the buffer and discards the response of any fetch that was in flight.
//
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched_o and
// perf_bubble_o counters. Without it the ports and counters are absent.
//
// Ports
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   imem_req_o          fetch request valid
//   imem_addr_o         fetch address (current fetch PC)
//   imem_gnt_i          request accepted (req & gnt = issued)
//   imem_rvalid_i       read data valid, one cycle after issue
//   imem_rdata_i        read data
//   instr_valid_o       buffer head valid toward decode
//   instr_ready_i       decode accepts the head (valid & ready = pop)
//   instr_o, pc_o       head instruction and its address (held when empty)
//   pc_src_i            redirect request
//   pc_target_i         redirect target
//   perf_fetched_o      (FETCH_PERF_EN) number of instructions popped
//   perf_bubble_o       (FETCH_PERF_EN) RUN cycles with instr_valid_o low
//
// State | meaning
//   BOOT | first cycle after reset release, no requests; latches a redirect
//   RUN  | normal fetching; redirects are handled without leaving RUN
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    FIFO_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    input  logic                   pc_src_i,
    input  logic [ADDR_WIDTH-1:0]  pc_target_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched_o,
    output logic [31:0]            perf_bubble_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   issue_pc;
    logic                    inflight;
    logic                    stale;

    logic [INSTR_WIDTH-1:0]  fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [INSTR_WIDTH-1:0]  head_instr;
    logic [ADDR_WIDTH-1:0]   head_pc;

    logic                    run;
    logic                    redirect;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [CNT_W:0]          occupancy;
    logic [CNT_W:0]          limit;
    logic [CNT_W-1:0]        remaining;
    logic [PTR_W-1:0]        rd_next;

    always_comb begin
        run           = (state == RUN);
        redirect      = run & pc_src_i;
        // A redirect hides the head for the cycle so nothing is popped from a
        // buffer that is about to be flushed.
        instr_valid_o = run & (count != '0) & ~pc_src_i;
        pop           = instr_valid_o & instr_ready_i;
        // Credit: buffered + in-flight words after this cycle's pop must leave
        // room for the word a new request would bring back.
        occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        limit         = DEPTH_L + {{CNT_W{1'b0}}, pop};
        imem_req_o    = run & ~pc_src_i & (occupancy < limit);
        issue         = imem_req_o & imem_gnt_i;
        // The response of a fetch issued just before a redirect lands in the
        // redirect cycle itself; drop it along with the flush.
        push          = imem_rvalid_i & inflight & ~stale & ~redirect;
        remaining     = count - CNT_W'(pop);
        rd_next       = rd_ptr + PTR_W'(pop);
        imem_addr_o   = fetch_pc;
        instr_o       = head_instr;
        pc_o          = head_pc;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            issue_pc <= RESET_PC;
            inflight <= 1'b0;
            stale    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    inflight <= 1'b0;
                    stale    <= 1'b0;
                    if (pc_src_i) begin
                        fetch_pc <= pc_target_i;
                    end
                end
                RUN: begin
                    if (pc_src_i) begin
                        fetch_pc <= pc_target_i;
                        stale    <= inflight;
                        inflight <= 1'b0;
                    end else begin
                        stale    <= 1'b0;
                        inflight <= issue;
                        if (issue) begin
                            issue_pc <= fetch_pc;
                            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed after being written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata_i;
            fifo_pc[wr_ptr]    <= issue_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_instr <= '0;
            head_pc    <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= remaining + CNT_W'(push);
            // Registered head: next oldest entry, else the word arriving into
            // an empty buffer, else hold the last value.
            if (remaining != '0) begin
                head_instr <= fifo_instr[rd_next];
                head_pc    <= fifo_pc[rd_next];
            end else if (push) begin
                head_instr <= imem_rdata_i;
                head_pc    <= issue_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetched_o <= '0;
            perf_bubble_o  <= '0;
        end else begin
            if (pop) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (run && !instr_valid_o) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
        end
    end
`endif

    // The credit rule guarantees a full buffer never receives a word unless it
    // also pops one in the same cycle.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && !pop && (count == FULL_C)));

endmodule
